xor_stream_decrypter: RTL and testbench

- Receive side of the team's 16-bit XOR word cipher.
- Takes ciphertext words over a valid/ready handshake and XORs each word with a 16-bit LFSR keystream to recover plaintext.
- The keystream advances by one step per accepted word, so it stays in lock-step with the transmit-side encrypter when both are loaded with the same seed.
- Sits between the link receiver and the consumer; provides one registered output stage.

---
 rtl/xor_stream_decrypter.sv | 71 +++++++
 tb/tb_xor_stream_decrypter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/xor_stream_decrypter.sv
// xor_stream_decrypter: XORs ciphertext words with a 16-bit Fibonacci LFSR keystream behind a one-deep registered output stage; ports: clk, rst (async high), seed_load/seed, in_valid/in_data/in_ready, out_valid/out_data/out_ready, word_count, seeded
module xor_stream_decrypter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8,
  parameter logic [WIDTH-1:0] DEF_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_count,
  output logic             seeded
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, out_data_q, out_data_d;
  logic out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic accept, handoff, fb;
  assign seeded = state_q == RUN;
  assign in_ready = seeded & ~seed_load & (~out_valid_q | out_ready);
  assign accept = in_valid & in_ready;
  assign handoff = out_valid_q & out_ready;
  assign fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign word_count = cnt_q;
  always_comb begin
    state_d = state_q;
    lfsr_d = lfsr_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    cnt_d = cnt_q;
    if (seed_load) begin
      state_d = RUN;
      lfsr_d = seed == '0 ? DEF_SEED : seed;
      out_valid_d = 1'b0;
      cnt_d = '0;
    end else begin
      if (accept) begin
        out_data_d = in_data ^ lfsr_q;
        lfsr_d = {fb, lfsr_q[WIDTH-1:1]};
        out_valid_d = 1'b1;
      end else if (handoff) begin
        out_valid_d = 1'b0;
      end
      if (handoff) cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_xor_stream_decrypter.sv
// tb_xor_stream_decrypter: directed self-checking bench for xor_stream_decrypter
module tb_xor_stream_decrypter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic seed_load = 1'b0;
  logic [15:0] seed = '0;
  logic in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic in_ready;
  logic out_valid;
  logic [15:0] out_data;
  logic out_ready = 1'b0;
  logic [7:0] word_count;
  logic seeded;
  int checks = 0;
  int failures = 0;
  xor_stream_decrypter dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .word_count(word_count), .seeded(seeded)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [15:0] s);
    seed_load = 1'b1;
    seed = s;
    step();
    seed_load = 1'b0;
  endtask
  initial begin
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    repeat (2) step();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h5555;
    out_ready = 1'b1;
    repeat (3) begin
      #1 chk("idle_in_ready", in_ready, 0);
      step();
      chk("idle_out_valid", out_valid, 0);
      chk("idle_count", word_count, 0);
      chk("idle_seeded", seeded, 0);
    end
    in_valid = 1'b0;
    load(16'hACE1);
    chk("seed_seeded", seeded, 1);
    chk("seed_out_valid", out_valid, 0);
    in_valid = 1'b1;
    in_data = 16'h0000;
    #1 chk("basic_in_ready", in_ready, 1);
    step();
    chk("basic_v0", out_valid, 1);
    chk("basic_d0", out_data, 16'hACE1);
    in_data = 16'hFFFF;
    step();
    chk("basic_v1", out_valid, 1);
    chk("basic_d1", out_data, 16'hA98F);
    in_valid = 1'b0;
    step();
    chk("basic_drain", out_valid, 0);
    chk("basic_hold", out_data, 16'hA98F);
    chk("basic_count", word_count, 2);
    load(16'h0000);
    chk("zero_count", word_count, 0);
    in_valid = 1'b1;
    in_data = 16'h1234;
    step();
    in_valid = 1'b0;
    chk("zero_d", out_data, 16'hBED5);
    step();
    chk("zero_count1", word_count, 1);
    load(16'hACE1);
    in_valid = 1'b1;
    in_data = 16'h0000;
    out_ready = 1'b0;
    step();
    chk("bp_d0", out_data, 16'hACE1);
    repeat (3) begin
      #1 chk("bp_in_ready", in_ready, 0);
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_hold", out_data, 16'hACE1);
      chk("bp_count", word_count, 0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 1);
    step();
    chk("bp_d1", out_data, 16'h5670);
    chk("bp_count1", word_count, 1);
    in_valid = 1'b0;
    step();
    chk("bp_count2", word_count, 2);
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    chk("rs_pending", out_valid, 1);
    seed_load = 1'b1;
    seed = 16'hACE1;
    out_ready = 1'b1;
    #1 chk("rs_in_ready", in_ready, 0);
    step();
    seed_load = 1'b0;
    chk("rs_valid", out_valid, 0);
    chk("rs_count", word_count, 0);
    step();
    chk("rs_d", out_data, 16'hACE1);
    chk("rs_count0", word_count, 0);
    in_valid = 1'b0;
    step();
    chk("rs_count1", word_count, 1);
    load(16'h1111);
    in_valid = 1'b1;
    repeat (256) step();
    chk("wrap_255", word_count, 255);
    in_valid = 1'b0;
    step();
    chk("wrap_0", word_count, 0);
    in_valid = 1'b1;
    repeat (2) step();
    chk("pre_rst_count", word_count, 1);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_seeded", seeded, 0);
    chk("arst_count", word_count, 0);
    chk("arst_in_ready", in_ready, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_ready", in_ready, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
